// File: rtl/sim_check_sched.sv
// rtl/sim_check_sched.sv - commit-PC scheduler for the single-port golden-model checker
//
// Purpose: buffers retired PCs from a 2-lane commit stage in program order and issues
//   them to the checker one at a time (1 cycle DRIVE, then 1 cycle RESP). Counts
//   matches and mismatches, and halts after MAX_MISS mismatches (0 = never halt).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cm0_valid/cm0_pc         commit lane 0 (older)
//   cm1_valid/cm1_pc         commit lane 1 (younger)
//   cm_ready                 FIFO can accept two entries this cycle
//   chk_pc                   registered PC presented to the checker
//   chk_ref_pc/insn/miss     checker response, sampled in RESP only
//   mm_valid/pc/ref_pc/insn  mismatch pulse and details of the last mismatch
//   mm_count, chk_count      mismatch (saturating) and match (wrapping) counters
//   halt, ovf_err, lane_err  sticky status flags
module sim_check_sched #(
   parameter int          DEPTH    = 16,
   parameter logic [63:0] IDLE_PC  = 64'h0,
   parameter int          MAX_MISS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cm0_valid,
   input  logic [63:0] cm0_pc,
   input  logic        cm1_valid,
   input  logic [63:0] cm1_pc,
   output logic        cm_ready,
   output logic [63:0] chk_pc,
   input  logic [63:0] chk_ref_pc,
   input  logic [31:0] chk_ref_insn,
   input  logic        chk_miss,
   output logic        mm_valid,
   output logic [63:0] mm_pc,
   output logic [63:0] mm_ref_pc,
   output logic [31:0] mm_insn,
   output logic [15:0] mm_count,
   output logic [31:0] chk_count,
   output logic        halt,
   output logic        ovf_err,
   output logic        lane_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, DRIVE, RESP, HALT} state_t;

   state_t         state_q;
   logic [63:0]    mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, rd_nxt;
   logic [CW-1:0]  count_q, count_d;
   logic [63:0]    chk_pc_q, mm_pc_q, mm_ref_pc_q;
   logic [31:0]    mm_insn_q, chk_count_q;
   logic [15:0]    mm_count_q, mm_count_d;
   logic           mm_valid_q, halt_q, ovf_err_q, lane_err_q;

   logic           any_push, push_ok, both_lanes, pop, halt_now;
   logic [1:0]     n_push;
   logic [63:0]    first_pc, head_pc, next_head_pc;

   always_comb begin
      cm_ready   = (count_q <= CW'(DEPTH - 2)) && !halt_q;
      any_push   = cm0_valid || cm1_valid;
      push_ok    = any_push && cm_ready;
      both_lanes = cm0_valid && cm1_valid;
      n_push     = push_ok ? (both_lanes ? 2'd2 : 2'd1) : 2'd0;
      // A lone lane-1 commit is still stored, as a single entry.
      first_pc   = cm0_valid ? cm0_pc : cm1_pc;
      pop        = (state_q == RESP);
      wr_ptr_d   = wr_ptr_q + AW'(n_push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      count_d    = count_q + CW'(n_push) - CW'(pop);
      rd_nxt     = rd_ptr_q + AW'(1);
      head_pc    = mem_q[rd_ptr_q];
      // When the popped entry was the last one, the next head can only be an
      // entry being written this same cycle, so bypass it from the commit lanes.
      next_head_pc = (count_q > CW'(1)) ? mem_q[rd_nxt] : first_pc;
      mm_count_d = mm_count_q;
      if (pop && chk_miss && (mm_count_q != 16'hFFFF)) begin
         mm_count_d = mm_count_q + 16'd1;
      end
      halt_now = (MAX_MISS != 0) && ({16'd0, mm_count_d} >= 32'(MAX_MISS));
   end

   // Storage is not reset; count/pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= first_pc;
         if (both_lanes) begin
            mem_q[wr_ptr_q + AW'(1)] <= cm1_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         chk_pc_q    <= IDLE_PC;
         mm_valid_q  <= 1'b0;
         mm_pc_q     <= '0;
         mm_ref_pc_q <= '0;
         mm_insn_q   <= '0;
         mm_count_q  <= '0;
         chk_count_q <= '0;
         halt_q      <= 1'b0;
         ovf_err_q   <= 1'b0;
         lane_err_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mm_count_q <= mm_count_d;
         mm_valid_q <= 1'b0;
         if (any_push && !cm_ready) begin
            ovf_err_q <= 1'b1;
         end
         if (cm1_valid && !cm0_valid) begin
            lane_err_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (count_q != '0) begin
                  chk_pc_q <= head_pc;
                  state_q  <= DRIVE;
               end
            end
            DRIVE: begin
               chk_pc_q <= IDLE_PC;
               state_q  <= RESP;
            end
            RESP: begin
               if (chk_miss) begin
                  mm_valid_q  <= 1'b1;
                  mm_pc_q     <= head_pc;
                  mm_ref_pc_q <= chk_ref_pc;
                  mm_insn_q   <= chk_ref_insn;
               end else begin
                  chk_count_q <= chk_count_q + 32'd1;
               end
               if (halt_now) begin
                  halt_q  <= 1'b1;
                  state_q <= HALT;
               end else if (count_d != '0) begin
                  chk_pc_q <= next_head_pc;
                  state_q  <= DRIVE;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               chk_pc_q <= IDLE_PC;
            end
         endcase
      end
   end

   assign chk_pc    = chk_pc_q;
   assign mm_valid  = mm_valid_q;
   assign mm_pc     = mm_pc_q;
   assign mm_ref_pc = mm_ref_pc_q;
   assign mm_insn   = mm_insn_q;
   assign mm_count  = mm_count_q;
   assign chk_count = chk_count_q;
   assign halt      = halt_q;
   assign ovf_err   = ovf_err_q;
   assign lane_err  = lane_err_q;

endmodule

// File: tb/tb_sim_check_sched.sv
// tb/tb_sim_check_sched.sv - scoreboard bench for sim_check_sched
module tb_sim_check_sched;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] ref_pc;
      logic [31:0] insn;
   } mm_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cm0_valid = 1'b0, cm1_valid = 1'b0;
   logic [63:0] cm0_pc = '0, cm1_pc = '0;
   logic        cm_ready;
   logic [63:0] chk_pc;
   logic [63:0] chk_ref_pc = '0;
   logic [31:0] chk_ref_insn = '0;
   logic        chk_miss = 1'b0;
   logic        mm_valid;
   logic [63:0] mm_pc, mm_ref_pc;
   logic [31:0] mm_insn;
   logic [15:0] mm_count;
   logic [31:0] chk_count;
   logic        halt, ovf_err, lane_err;

   int total = 0;
   int bad = 0;
   int exp_chk = 0;
   logic [63:0] exp_pc_q[$];
   mm_t         exp_mm_q[$];

   sim_check_sched #(.DEPTH(4), .IDLE_PC(64'h0), .MAX_MISS(1)) dut (
      .clk(clk), .rst(rst),
      .cm0_valid(cm0_valid), .cm0_pc(cm0_pc),
      .cm1_valid(cm1_valid), .cm1_pc(cm1_pc),
      .cm_ready(cm_ready), .chk_pc(chk_pc),
      .chk_ref_pc(chk_ref_pc), .chk_ref_insn(chk_ref_insn), .chk_miss(chk_miss),
      .mm_valid(mm_valid), .mm_pc(mm_pc), .mm_ref_pc(mm_ref_pc), .mm_insn(mm_insn),
      .mm_count(mm_count), .chk_count(chk_count),
      .halt(halt), .ovf_err(ovf_err), .lane_err(lane_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [63:0] p0,
                        input logic v1, input logic [63:0] p1);
      cm0_valid = v0; cm0_pc = p0;
      cm1_valid = v1; cm1_pc = p1;
   endtask

   // Monitor: every non-idle chk_pc and every mismatch pulse is checked
   // against the next expectation queued by the stimulus.
   always @(negedge clk) begin
      if (!rst) begin
         if (chk_pc !== 64'h0) begin
            if (exp_pc_q.size() == 0) chk("unexpected_drive", chk_pc, 64'h0);
            else chk("drive_pc", chk_pc, exp_pc_q.pop_front());
         end
         if (mm_valid === 1'b1) begin
            if (exp_mm_q.size() == 0) begin
               chk("unexpected_mm_valid", 64'(mm_valid), 64'h0);
            end else begin
               mm_t e;
               e = exp_mm_q.pop_front();
               chk("mm_pc", mm_pc, e.pc);
               chk("mm_ref_pc", mm_ref_pc, e.ref_pc);
               chk("mm_insn", 64'(mm_insn), 64'(e.insn));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset
      tick(); tick();
      chk("rst_chk_pc", chk_pc, 64'h0);
      chk("rst_cm_ready", 64'(cm_ready), 64'h1);
      chk("rst_halt", 64'(halt), 64'h0);
      chk("rst_mm_count", 64'(mm_count), 64'h0);
      chk("rst_chk_count", 64'(chk_count), 64'h0);
      chk("rst_mm_valid", 64'(mm_valid), 64'h0);
      chk("rst_ovf_err", 64'(ovf_err), 64'h0);
      rst = 1'b0;
      tick();

      // 2. single push, latency
      drive(1, 64'h8000_0000, 0, 0); exp_pc_q.push_back(64'h8000_0000);
      tick(); drive(0, 0, 0, 0);
      chk("t2_chk_pc_t1", chk_pc, 64'h0);
      tick(); chk("t2_chk_pc_t2", chk_pc, 64'h8000_0000);
      tick(); chk("t2_chk_pc_t3", chk_pc, 64'h0);
      tick(); exp_chk += 1;
      chk("t2_chk_count_t4", 64'(chk_count), 64'(exp_chk));

      // 3. dual-lane push
      drive(1, 64'h8000_0000, 1, 64'h8000_0004);
      exp_pc_q.push_back(64'h8000_0000); exp_pc_q.push_back(64'h8000_0004);
      tick(); drive(0, 0, 0, 0);
      tick(); chk("t3_chk_pc_t2", chk_pc, 64'h8000_0000);
      tick(); chk("t3_chk_pc_t3", chk_pc, 64'h0);
      tick(); chk("t3_chk_pc_t4", chk_pc, 64'h8000_0004);
      tick(); tick(); exp_chk += 2;
      chk("t3_chk_count", 64'(chk_count), 64'(exp_chk));

      // lane 1 without lane 0
      drive(0, 0, 1, 64'h8000_0010); exp_pc_q.push_back(64'h8000_0010);
      tick(); drive(0, 0, 0, 0);
      chk("lane_err", 64'(lane_err), 64'h1);
      tick(); tick(); tick(); exp_chk += 1;
      chk("lane_chk_count", 64'(chk_count), 64'(exp_chk));

      // 5. overflow with DEPTH=4
      drive(1, 64'h9000_0000, 1, 64'h9000_0004);
      exp_pc_q.push_back(64'h9000_0000); exp_pc_q.push_back(64'h9000_0004);
      tick(); chk("t5_ready_cnt2", 64'(cm_ready), 64'h1);
      drive(1, 64'h9000_0008, 1, 64'h9000_000c);
      exp_pc_q.push_back(64'h9000_0008); exp_pc_q.push_back(64'h9000_000c);
      tick(); chk("t5_ready_cnt4", 64'(cm_ready), 64'h0);
      chk("t5_ovf_before", 64'(ovf_err), 64'h0);
      drive(1, 64'h9000_0010, 1, 64'h9000_0014);
      tick(); drive(0, 0, 0, 0);
      chk("t5_ovf_after", 64'(ovf_err), 64'h1);
      chk("t5_ready_still0", 64'(cm_ready), 64'h0);
      tick(); chk("t5_ready_cnt3", 64'(cm_ready), 64'h0);
      for (int i = 0; i < 6; i++) tick();
      exp_chk += 4;
      chk("t5_chk_count", 64'(chk_count), 64'(exp_chk));
      chk("t5_ready_drained", 64'(cm_ready), 64'h1);

      // 4. mismatch then halt
      chk_miss = 1'b1; chk_ref_pc = 64'h8000_0008; chk_ref_insn = 32'h0000_006f;
      drive(1, 64'h8000_0000, 0, 0); exp_pc_q.push_back(64'h8000_0000);
      exp_mm_q.push_back('{pc: 64'h8000_0000, ref_pc: 64'h8000_0008, insn: 32'h0000_006f});
      tick(); drive(0, 0, 0, 0);
      tick(); tick(); tick();
      chk("t4_halt", 64'(halt), 64'h1);
      chk("t4_cm_ready", 64'(cm_ready), 64'h0);
      chk("t4_mm_count", 64'(mm_count), 64'h1);
      chk("t4_chk_count", 64'(chk_count), 64'(exp_chk));
      drive(1, 64'h8000_0020, 0, 0);
      tick(); drive(0, 0, 0, 0);
      chk("t4_mm_pulse", 64'(mm_valid), 64'h0);
      for (int i = 0; i < 4; i++) tick();
      chk("t4_chk_pc_idle", chk_pc, 64'h0);
      chk("t4_halt_sticky", 64'(halt), 64'h1);

      // 6. reset during RESP
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      chk("t6_halt_clr", 64'(halt), 64'h0);
      chk("t6_lane_clr", 64'(lane_err), 64'h0);
      drive(1, 64'h8000_0000, 0, 0); exp_pc_q.push_back(64'h8000_0000);
      tick(); drive(0, 0, 0, 0);
      tick(); tick();
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("t6_mm_valid", 64'(mm_valid), 64'h0);
      chk("t6_mm_count", 64'(mm_count), 64'h0);
      chk("t6_cm_ready", 64'(cm_ready), 64'h1);
      chk_miss = 1'b0;
      drive(1, 64'h8000_0000, 0, 0); exp_pc_q.push_back(64'h8000_0000);
      tick(); drive(0, 0, 0, 0);
      chk("t6_chk_pc_t1", chk_pc, 64'h0);
      tick(); chk("t6_chk_pc_t2", chk_pc, 64'h8000_0000);
      tick(); tick();
      chk("t6_chk_count", 64'(chk_count), 64'h1);
      tick(); tick();

      chk("pc_queue_empty", 64'(exp_pc_q.size()), 64'h0);
      chk("mm_queue_empty", 64'(exp_mm_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
